// File: rtl/registrador_pipeline.sv
// registrador_pipeline
//   Pipeline-stage register with valid/ready handshake and a 2-entry skid
//   buffer. It sits between the MIPS stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   in_ready is decoded only from the state register, so there is no
//   combinational path from out_ready back to upstream. When downstream
//   stalls, the skid entry absorbs the word that was already in flight.
//
// Ports
//   ck              clock, rising edge
//   reset_register  asynchronous reset, active high
//   in / in_valid   upstream data and valid
//   in_ready        stage can accept (registered decode)
//   flush           synchronous kill of stage contents
//   out / out_valid downstream data (main register) and valid
//   out_ready       downstream accepts
//   occupancy       valid entries held: 0, 1 or 2
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | nothing valid; out shows the last main value (or RESET_VALUE)
// FULL  | main valid; can still accept one word per cycle
// SKID  | main and skid both valid; upstream is stalled (in_ready=0)

module registrador_pipeline #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             ck,
  input  logic             reset_register,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // The state encoding equals the occupancy count, so occupancy is the
  // state register itself.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Flush wins over any transfer in the same cycle; the input is dropped.
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_d  = in;
            state_d = FULL;
          end
        end
        FULL: begin
          if (in_valid && out_ready) begin
            main_d = in;
          end else if (in_valid) begin
            // Downstream stalled while a word arrives: park it in skid.
            skid_d  = in;
            state_d = SKID;
          end else if (out_ready) begin
            // Main keeps its value; only the valid flag drops.
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_ready) begin
            main_d  = skid_q;
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge ck or posedge reset_register) begin
    if (reset_register) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out       = main_q;
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != SKID);
  assign occupancy = state_q;

endmodule

// File: tb/tb_registrador_pipeline.sv
module tb_registrador_pipeline;

  logic        ck = 1'b0;
  logic        reset_register;
  logic [31:0] din;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] dout;
  logic [1:0]  occupancy;

  logic [7:0]  din8, dout8;
  logic        in_valid8, in_ready8, flush8, out_valid8, out_ready8;
  logic [1:0]  occupancy8;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_q[$];

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic [31:0] e_out;
    logic        e_ov;
    logic        e_ir;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vecs[22];

  always #5 ck = ~ck;

  registrador_pipeline #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .ck(ck), .reset_register(reset_register),
    .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .out(dout), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  registrador_pipeline #(.WIDTH(8), .RESET_VALUE(8'h7F)) dut8 (
    .ck(ck), .reset_register(reset_register),
    .in(din8), .in_valid(in_valid8), .in_ready(in_ready8),
    .flush(flush8),
    .out(dout8), .out_valid(out_valid8), .out_ready(out_ready8),
    .occupancy(occupancy8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge: drives inputs, runs the scoreboard against the
  // reference queue for the coming edge, then advances to the next negedge.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    int sz;
    logic [31:0] exp_w;
    in_valid  = iv;
    din       = d;
    out_ready = ordy;
    flush     = fl;
    sz = model_q.size();
    if (fl) begin
      model_q.delete();
    end else begin
      if (sz > 0 && ordy) begin
        exp_w = model_q.pop_front();
        chk("sb_out_valid", 32'(out_valid), 32'd1);
        chk("sb_out_data", dout, exp_w);
      end
      if (iv && sz < 2) model_q.push_back(d);
    end
    @(posedge ck);
    @(negedge ck);
    chk("model_occ", 32'(occupancy), 32'(model_q.size()));
    chk("model_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out"}, dout, 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_occ"}, 32'(occupancy), 32'd0);
  endtask

  // Async reset asserted between edges; checked before the next rising edge.
  task automatic mid_cycle_reset(input string tag);
    #2 reset_register = 1'b1;
    #1 check_reset_state(tag);
    model_q.delete();
    #1 reset_register = 1'b0;
    @(negedge ck);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h1,    1'b1, 1'b0, 32'h1, 1'b1, 1'b1, 2'd1};
    vecs[1]  = '{1'b1, 32'h2,    1'b1, 1'b0, 32'h2, 1'b1, 1'b1, 2'd1};
    vecs[2]  = '{1'b1, 32'h3,    1'b1, 1'b0, 32'h3, 1'b1, 1'b1, 2'd1};
    vecs[3]  = '{1'b1, 32'h4,    1'b1, 1'b0, 32'h4, 1'b1, 1'b1, 2'd1};
    vecs[4]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h4, 1'b0, 1'b1, 2'd0};
    vecs[5]  = '{1'b1, 32'hA,    1'b1, 1'b0, 32'hA, 1'b1, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 32'hB,    1'b0, 1'b0, 32'hA, 1'b1, 1'b0, 2'd2};
    vecs[7]  = '{1'b1, 32'hEEE,  1'b0, 1'b0, 32'hA, 1'b1, 1'b0, 2'd2};
    vecs[8]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'hA, 1'b1, 1'b0, 2'd2};
    vecs[9]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'hA, 1'b1, 1'b0, 2'd2};
    vecs[10] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'hB, 1'b1, 1'b1, 2'd1};
    vecs[11] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'hB, 1'b0, 1'b1, 2'd0};
    vecs[12] = '{1'b1, 32'hA,    1'b0, 1'b0, 32'hA, 1'b1, 1'b1, 2'd1};
    vecs[13] = '{1'b1, 32'hB,    1'b0, 1'b0, 32'hA, 1'b1, 1'b0, 2'd2};
    vecs[14] = '{1'b1, 32'hC,    1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 2'd0};
    vecs[15] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0};
    vecs[16] = '{1'b1, 32'h5,    1'b1, 1'b0, 32'h5, 1'b1, 1'b1, 2'd1};
    vecs[17] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h5, 1'b0, 1'b1, 2'd0};
    vecs[18] = '{1'b1, 32'h6,    1'b0, 1'b0, 32'h6, 1'b1, 1'b1, 2'd1};
    vecs[19] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h6, 1'b1, 1'b1, 2'd1};
    vecs[20] = '{1'b1, 32'h7,    1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 2'd0};
    vecs[21] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0};

    reset_register = 1'b1;
    din = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    din8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b0; flush8 = 1'b0;
    @(negedge ck);
    @(negedge ck);
    check_reset_state("reset");
    chk("reset_out8", 32'(dout8), 32'h7F);
    reset_register = 1'b0;
    @(negedge ck);

    // Table-driven main sequence: streaming, skid, flush, drain.
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("vec%0d_out", i), dout, vecs[i].e_out);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vecs[i].e_occ));
    end

    // Async reset while FULL holding DEADBEEF.
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("full_before_reset", dout, 32'hDEADBEEF);
    in_valid = 1'b0;
    mid_cycle_reset("rst_full");

    // Async reset while SKID with pending data.
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    chk("skid_before_reset", 32'(occupancy), 32'd2);
    in_valid = 1'b0;
    mid_cycle_reset("rst_skid");
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("after_rst_skid_occ", 32'(occupancy), 32'd0);

    // Random back-pressure traffic checked purely by the scoreboard.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0));
    end
    // Drain whatever is left.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drained_occ", 32'(occupancy), 32'd0);

    // 8-bit instance: streaming 01..04 then flush back to 7F.
    out_ready8 = 1'b1;
    in_valid8  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      din8 = 8'(i);
      @(posedge ck);
      @(negedge ck);
      chk($sformatf("w8_stream%0d_out", i), 32'(dout8), 32'(i));
      chk($sformatf("w8_stream%0d_valid", i), 32'(out_valid8), 32'd1);
      chk($sformatf("w8_stream%0d_in_ready", i), 32'(in_ready8), 32'd1);
      chk($sformatf("w8_stream%0d_occ", i), 32'(occupancy8), 32'd1);
    end
    din8 = 8'h55;
    out_ready8 = 1'b0;
    flush8 = 1'b1;
    @(posedge ck);
    @(negedge ck);
    flush8 = 1'b0;
    in_valid8 = 1'b0;
    chk("w8_flush_out", 32'(dout8), 32'h7F);
    chk("w8_flush_valid", 32'(out_valid8), 32'd0);
    chk("w8_flush_occ", 32'(occupancy8), 32'd0);
    chk("w8_flush_in_ready", 32'(in_ready8), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/registrador_pipeline.md
Name: registrador_pipeline

Overview:
- Parametrised successor of the plain reset register: a WIDTH-bit pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and an occupancy output.
- Sits between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Downstream stalls are absorbed without a combinational ready path back to upstream.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- RESET_VALUE, 0 (WIDTH bits), value driven on out after reset and after flush.

Ports:
- ck  input  1  clock; all state updates on the rising edge.
- reset_register  input  1  asynchronous, active-high reset.
- in  input  WIDTH  upstream data.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
- flush  input  1  synchronous clear of stage contents (branch/exception kill).
- out  output  WIDTH  downstream data; equals main register.
- out_valid  output  1  main register holds valid data.
- out_ready  input  1  downstream accepts.
- occupancy  output  2  number of valid entries held: 0, 1 or 2.

Behaviour:
- Reset (async, active-high) forces the following immediately, independent of ck:
  - state=EMPTY, main=skid=RESET_VALUE.
  - out=RESET_VALUE, out_valid=0, in_ready=1, occupancy=0.
- Transfers:
  - Input transfer = in_valid & in_ready at the rising edge.
  - Output transfer = out_valid & out_ready at the rising edge.
- States (occupancy 0/1/2). in_ready=1 in EMPTY and FULL, 0 in SKID. out_valid=1 in FULL and SKID.
- Transitions, evaluated when flush=0:
  - EMPTY, in_valid=1: main<=in, go FULL.
  - EMPTY, in_valid=0: hold.
  - FULL, in_valid=1, out_ready=1: main<=in, stay FULL.
  - FULL, in_valid=1, out_ready=0: skid<=in, go SKID; main unchanged.
  - FULL, in_valid=0, out_ready=1: go EMPTY; main retains value, out_valid=0.
  - FULL, in_valid=0, out_ready=0: hold.
  - SKID, out_ready=1: main<=skid, go FULL; in ignored because in_ready=0.
  - SKID, out_ready=0: hold everything.
- Latency: one cycle from input transfer to out_valid. Throughput is one word per cycle while out_ready=1.
- Stability: while out_valid=1 and out_ready=0, out holds stable and out_valid stays 1.
- Ordering: words leave in arrival order; no word is lost or duplicated.
- Flush: synchronous, highest priority over any transfer in the same cycle.
  - Next state EMPTY, main=skid=RESET_VALUE, out_valid=0, occupancy=0, in_ready=1.
  - Any input presented in the flush cycle is dropped.
- Reset mid-operation: async reset overrides all states, including SKID with pending data; all contents are lost.
- Registers change only on the ck rising edge or on reset assertion.
- All data paths are exactly WIDTH bits; no arithmetic is performed.

Test Plan:
- Reset: assert reset_register mid-cycle with state FULL, main=32'hDEADBEEF -> out=0, out_valid=0, in_ready=1, occupancy=0 immediately, before the next ck edge.
- Streaming: out_ready=1, in_valid=1, in=1,2,3,4 on consecutive edges -> out=1,2,3,4 one cycle later each, out_valid=1 throughout, in_ready stays 1, occupancy=1.
- Back-pressure/skid:
  - Load 32'hA. Then out_ready=0 and in=32'hB with in_valid=1 -> occupancy=2, in_ready=0, out stays 32'hA.
  - Hold out_ready=0 three cycles -> no change.
  - out_ready=1 -> out=32'hB next cycle, in_ready=1.
- Flush priority:
  - From SKID (32'hA, 32'hB), assert flush with in_valid=1, in=32'hC, out_ready=1 -> next cycle out_valid=0, out=RESET_VALUE, occupancy=0.
  - 32'hC is never output.
- Drain: FULL with 32'h5, in_valid=0, out_ready=1 -> next cycle out_valid=0, occupancy=0, in_ready=1.
- Parameter sweep: WIDTH=8, RESET_VALUE=8'h7F -> out=8'h7F after reset and after flush; streaming scenario repeated with 8-bit values 8'h01..8'h04 yields the same cycle behaviour.
